// File: rtl/max7219_link_scheduler.sv
// max7219_link_scheduler
//   Owns the single MAX7219 serial link (daisy chain of NUM_CASCADES devices)
//   and schedules every register write onto it. After reset it replays the
//   five-frame power-up init, then arbitrates host commands against periodic
//   digit-refresh sweeps, handing one frame at a time to the SPI shifter via
//   a tx_start / tx_done handshake.
//
//   Optional build macro: MAX7219_LINK_WD_EN
//     defined   -> tx watchdog (WD_CYCLES) aborts a stuck frame and re-inits
//     undefined -> no watchdog, frames wait for tx_done forever, tx_timeout=0
module max7219_link_scheduler #(
   parameter int NUM_CASCADES = 1,
   parameter int INTENSITY    = 7,
   parameter int SCAN_LIMIT   = 7,
   parameter int REFRESH_DIV  = 50000,
   parameter int STARVE_MAX   = 4,
   parameter int WD_CYCLES    = 4096
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [64*NUM_CASCADES-1:0] row_data,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [7:0]                 cmd_addr,
   input  logic [8*NUM_CASCADES-1:0]  cmd_data,
   output logic                       tx_start,
   output logic [7:0]                 tx_addr,
   output logic [8*NUM_CASCADES-1:0]  tx_data,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic                       init_done,
   output logic                       refresh_overrun,
   output logic                       tx_timeout
);

   localparam int DW    = 8 * NUM_CASCADES;
   localparam int RW    = 64 * NUM_CASCADES;
   localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int STV_W = $clog2(STARVE_MAX + 2);

   localparam logic [2:0] S_INIT_ISSUE = 3'd0;
   localparam logic [2:0] S_INIT_WAIT  = 3'd1;
   localparam logic [2:0] S_IDLE       = 3'd2;
   localparam logic [2:0] S_ISSUE      = 3'd3;
   localparam logic [2:0] S_WAIT       = 3'd4;

   localparam logic [2:0] LAST_INIT_STEP = 3'd4;

   // Power-up register addresses, in replay order.
   function automatic logic [7:0] init_addr(input logic [2:0] step);
      case (step)
         3'd0:    init_addr = 8'h0F;   // display test off
         3'd1:    init_addr = 8'h0C;   // shutdown -> normal operation
         3'd2:    init_addr = 8'h0B;   // scan limit
         3'd3:    init_addr = 8'h0A;   // intensity
         default: init_addr = 8'h09;   // decode mode: raw segments
      endcase
   endfunction

   // Power-up register values; the same byte goes to every cascade.
   function automatic logic [7:0] init_value(input logic [2:0] step);
      case (step)
         3'd0:    init_value = 8'h00;
         3'd1:    init_value = 8'h01;
         3'd2:    init_value = 8'(SCAN_LIMIT);
         3'd3:    init_value = 8'(INTENSITY);
         default: init_value = 8'h00;
      endcase
   endfunction

   // Control state
   logic [2:0]       r_state;
   logic [2:0]       r_step;
   logic             r_init_done;
   logic             r_pending;
   logic [2:0]       r_sweep;
   logic [STV_W-1:0] r_starve;
   logic [REF_W-1:0] r_ref_cnt;
   logic             r_overrun;

   // Datapath registers (no reset: only meaningful once loaded)
   logic [7:0]       r_tx_addr;
   logic [DW-1:0]    r_tx_data;
   logic [RW-1:0]    r_snap;

   logic             w_in_init;
   logic             w_waiting;
   logic             w_issue;
   logic             w_idle;
   logic             w_starved;
   logic             w_host_grant;
   logic             w_ref_grant;
   logic             w_trigger;
   logic             w_wd_expire;
   logic [DW-1:0]    w_ref_data;
   logic [DW-1:0]    w_init_data;

   assign w_in_init = (r_state == S_INIT_ISSUE) || (r_state == S_INIT_WAIT);
   assign w_waiting = (r_state == S_INIT_WAIT)  || (r_state == S_WAIT);
   assign w_idle    = (r_state == S_IDLE);

   // A frame may only be launched into an idle shifter; otherwise retry next cycle.
   assign w_issue   = ((r_state == S_INIT_ISSUE) || (r_state == S_ISSUE)) && !tx_busy;

   // Host normally wins; after STARVE_MAX host grants against a pending
   // sweep, exactly one refresh digit is let through.
   assign w_starved    = r_pending && (r_starve == STV_W'(STARVE_MAX));
   assign w_host_grant = w_idle && cmd_valid && !w_starved;
   assign w_ref_grant  = w_idle && r_pending && !w_host_grant;

   assign w_trigger    = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));

   assign w_init_data  = {NUM_CASCADES{init_value(r_step)}};

   // Pick the current sweep digit out of every cascade's snapshot.
   always_comb begin
      w_ref_data = '0;
      for (int i = 0; i < NUM_CASCADES; i++) begin
         w_ref_data[8*i +: 8] = r_snap[64*i + 8*r_sweep +: 8];
      end
   end

   // Combinational outputs are forced low while reset is held so a frame
   // start is withdrawn in the same cycle reset arrives.
   assign cmd_ready       = reset_n && w_host_grant;
   assign tx_start        = reset_n && w_issue;
   assign tx_addr         = !reset_n ? 8'h00 : (w_in_init ? init_addr(r_step) : r_tx_addr);
   assign tx_data         = !reset_n ? '0    : (w_in_init ? w_init_data       : r_tx_data);
   assign init_done       = r_init_done;
   assign refresh_overrun = r_overrun;

`ifdef MAX7219_LINK_WD_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;

   // Counter holds k in the k-th cycle after tx_start, so expiry lands the
   // abort (and the tx_timeout pulse) exactly WD_CYCLES after the start.
   assign w_wd_expire = w_waiting && !tx_done && (r_wd_cnt == WD_W'(WD_CYCLES - 1));
   assign tx_timeout  = r_timeout;

   // Watchdog: restart on every frame launch, count while waiting for done.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_wd_expire;
         if (w_issue) begin
            r_wd_cnt <= WD_W'(1);
         end else if (w_waiting && !tx_done) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         end
      end
   end
`else
   // No watchdog: waits never expire. WD_CYCLES only matters when the
   // watchdog is built in.
   assign w_wd_expire = 1'b0 && (WD_CYCLES > 0);
   assign tx_timeout  = 1'b0;
`endif

   // Link FSM: init replay, then one frame at a time with arbitration in IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_INIT_ISSUE;
         r_step      <= 3'd0;
         r_init_done <= 1'b0;
      end else if (w_wd_expire) begin
         r_state     <= S_INIT_ISSUE;
         r_step      <= 3'd0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            S_INIT_ISSUE: begin
               if (w_issue) r_state <= S_INIT_WAIT;
            end
            S_INIT_WAIT: begin
               if (tx_done) begin
                  if (r_step == LAST_INIT_STEP) begin
                     r_state     <= S_IDLE;
                     r_step      <= 3'd0;
                     r_init_done <= 1'b1;
                  end else begin
                     r_state <= S_INIT_ISSUE;
                     r_step  <= r_step + 3'd1;
                  end
               end
            end
            S_IDLE: begin
               if (w_host_grant || w_ref_grant) r_state <= S_ISSUE;
            end
            S_ISSUE: begin
               if (w_issue) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (tx_done) r_state <= S_IDLE;
            end
            default: r_state <= S_INIT_ISSUE;
         endcase
      end
   end

   // Refresh timer, sweep progress, overrun pulse and starvation counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ref_cnt <= '0;
         r_pending <= 1'b0;
         r_sweep   <= 3'd0;
         r_starve  <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_ref_cnt <= w_trigger ? '0 : r_ref_cnt + REF_W'(1);
         // A trigger during an active sweep is reported, never queued.
         r_overrun <= w_trigger && r_pending;

         if (w_wd_expire) begin
            r_pending <= 1'b0;
            r_sweep   <= 3'd0;
         end else if (w_trigger && !r_pending) begin
            r_pending <= 1'b1;
            r_sweep   <= 3'd0;
         end else if (w_ref_grant) begin
            r_sweep <= r_sweep + 3'd1;
            if (r_sweep == 3'd7) r_pending <= 1'b0;
         end

         if (w_wd_expire || !r_pending || w_ref_grant) begin
            r_starve <= '0;
         end else if (w_host_grant) begin
            r_starve <= r_starve + STV_W'(1);
         end
      end
   end

   // Frame payload capture at grant time and row snapshot at sweep start.
   always_ff @(posedge clk) begin
      if (w_host_grant) begin
         r_tx_addr <= cmd_addr;
         r_tx_data <= cmd_data;
      end else if (w_ref_grant) begin
         r_tx_addr <= {5'd0, r_sweep} + 8'd1;
         r_tx_data <= w_ref_data;
      end
      if (w_trigger && !r_pending) begin
         r_snap <= row_data;
      end
   end

endmodule

// File: tb/tb_max7219_link_scheduler.sv
// Bench for max7219_link_scheduler: shifter model with 34-cycle frames,
// randomized host traffic and row data, transaction-level reference model.
module tb_max7219_link_scheduler;

   localparam int NC       = 2;
   localparam int DW       = 8 * NC;
   localparam int RW       = 64 * NC;
   localparam int DIV      = 400;
   localparam int SMAX     = 4;
   localparam int WD       = 100;
   localparam int DONE_LAT = 34;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic [RW-1:0] row_data  = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [7:0]    cmd_addr  = 8'h00;
   logic [DW-1:0] cmd_data  = '0;
   logic          tx_start;
   logic [7:0]    tx_addr;
   logic [DW-1:0] tx_data;
   logic          tx_busy   = 1'b0;
   logic          tx_done   = 1'b0;
   logic          init_done;
   logic          refresh_overrun;
   logic          tx_timeout;

   always #5 clk = ~clk;

   max7219_link_scheduler #(
      .NUM_CASCADES (NC),
      .INTENSITY    (7),
      .SCAN_LIMIT   (7),
      .REFRESH_DIV  (DIV),
      .STARVE_MAX   (SMAX),
      .WD_CYCLES    (WD)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .row_data        (row_data),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_addr        (cmd_addr),
      .cmd_data        (cmd_data),
      .tx_start        (tx_start),
      .tx_addr         (tx_addr),
      .tx_data         (tx_data),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done),
      .init_done       (init_done),
      .refresh_overrun (refresh_overrun),
      .tx_timeout      (tx_timeout)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Shifter: busy for the frame, tx_done 34 cycles after tx_start.
   bit withhold_done = 1'b0;
   int sh_cnt = 0;
   always @(posedge clk) begin
      if (!reset_n) begin
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
         sh_cnt  <= 0;
      end else begin
         tx_done <= 1'b0;
         if (tx_start && !tx_busy) begin
            tx_busy <= 1'b1;
            sh_cnt  <= 1;
         end else if (tx_busy) begin
            if (sh_cnt == DONE_LAT - 1) begin
               tx_busy <= 1'b0;
               tx_done <= !withhold_done;
            end else begin
               sh_cnt <= sh_cnt + 1;
            end
         end
      end
   end

   // Reference model state
   logic [7:0]    INIT_A [0:4] = '{8'h0F, 8'h0C, 8'h0B, 8'h0A, 8'h09};
   logic [7:0]    INIT_V [0:4] = '{8'h00, 8'h01, 8'h07, 8'h07, 8'h00};
   bit            m_en = 1'b1;
   int            m_cyc;
   bit            m_init_done;
   int            m_step;
   bit            m_free;
   bit            m_exp_start;
   logic [7:0]    m_exp_addr;
   logic [DW-1:0] m_exp_data;
   bit            m_pend;
   int            m_sweep;
   int            m_starve;
   logic [RW-1:0] m_snap;
   bit            m_ovr;
   bit            acc_flag;
   int            n_starts = 0;

   task automatic model_reset();
      m_cyc       = 0;
      m_init_done = 1'b0;
      m_step      = 0;
      m_free      = 1'b0;
      m_exp_start = 1'b1;
      m_exp_addr  = INIT_A[0];
      m_exp_data  = {NC{INIT_V[0]}};
      m_pend      = 1'b0;
      m_sweep     = 0;
      m_starve    = 0;
      m_ovr       = 1'b0;
      acc_flag    = 1'b0;
   endtask

   // Per-cycle comparison against the model, then advance the model.
   always @(negedge clk) begin
      bit host_win, ref_win, trig, pend_old;
      if (!reset_n) begin
         model_reset();
      end else if (m_en) begin
         pend_old = m_pend;
         host_win = m_free && m_init_done && cmd_valid && !(m_pend && m_starve == SMAX);
         ref_win  = m_free && m_init_done && m_pend && !host_win;
         check_eq("cmd_ready", cmd_ready, host_win);
         check_eq("tx_start", tx_start, m_exp_start);
         if (m_exp_start) begin
            check_eq("tx_addr", tx_addr, m_exp_addr);
            check_eq("tx_data", tx_data, m_exp_data);
         end
         check_eq("init_done", init_done, m_init_done);
         check_eq("refresh_overrun", refresh_overrun, m_ovr);
         check_eq("tx_timeout", tx_timeout, 1'b0);
         acc_flag = cmd_valid && cmd_ready;
         if (tx_start) n_starts++;

         m_exp_start = 1'b0;
         if (tx_done) begin
            if (!m_init_done) begin
               m_step++;
               if (m_step == 5) begin
                  m_init_done = 1'b1;
                  m_free      = 1'b1;
               end else begin
                  m_exp_start = 1'b1;
                  m_exp_addr  = INIT_A[m_step];
                  m_exp_data  = {NC{INIT_V[m_step]}};
               end
            end else begin
               m_free = 1'b1;
            end
         end
         if (host_win) begin
            m_free      = 1'b0;
            m_exp_start = 1'b1;
            m_exp_addr  = cmd_addr;
            m_exp_data  = cmd_data;
            if (pend_old) m_starve++;
         end else if (ref_win) begin
            m_free      = 1'b0;
            m_exp_start = 1'b1;
            m_exp_addr  = 8'(m_sweep + 1);
            for (int c = 0; c < NC; c++) m_exp_data[8*c +: 8] = m_snap[64*c + 8*m_sweep +: 8];
            m_starve = 0;
            if (m_sweep == 7) m_pend = 1'b0;
            m_sweep = (m_sweep + 1) % 8;
         end
         if (!pend_old) m_starve = 0;
         trig  = (m_cyc % DIV) == DIV - 1;
         m_ovr = trig && pend_old;
         if (trig && !pend_old) begin
            m_pend  = 1'b1;
            m_snap  = row_data;
            m_sweep = 0;
         end
         m_cyc++;
      end
   end

   task automatic new_cmd();
      cmd_addr = 8'($urandom_range(0, 255));
      cmd_data = DW'($urandom);
   endtask

   // mode 0: random host traffic and row data, 1: host always requesting, 2: host silent
   task automatic run_phase(input int ncyc, input int mode);
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         if (mode == 2) begin
            cmd_valid = 1'b0;
         end else if (!cmd_valid || acc_flag) begin
            cmd_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
            new_cmd();
         end
         if (mode == 0 && $urandom_range(0, 49) == 0) begin
            for (int w = 0; w < RW / 32; w++) row_data[32*w +: 32] = $urandom;
         end
      end
   endtask

   initial begin
      bit hit;
      int k;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tx_start", tx_start, 1'b0);
      check_eq("rst_cmd_ready", cmd_ready, 1'b0);
      check_eq("rst_init_done", init_done, 1'b0);
      check_eq("rst_overrun", refresh_overrun, 1'b0);
      check_eq("rst_timeout", tx_timeout, 1'b0);
      check_eq("rst_tx_addr", tx_addr, 8'h00);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Reset while the third init frame is in flight; init must replay from 0F.
      for (k = 0; k < 500 && n_starts < 3; k++) @(posedge clk);
      check_eq("init_step2_reached", (n_starts >= 3), 1'b1);
      repeat (10) @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      check_eq("midinit_rst_tx_start", tx_start, 1'b0);
      check_eq("midinit_rst_init_done", init_done, 1'b0);
      for (int d = 0; d < 8; d++) begin
         for (int c = 0; c < NC; c++) row_data[64*c + 8*d +: 8] = 8'(16 * c + d);
      end
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_eq("replay_tx_start", tx_start, 1'b1);
      check_eq("replay_tx_addr", tx_addr, 8'h0F);

      // Quiet host: init then refresh sweeps of the fixed digit pattern.
      run_phase(1000, 2);

      // Directed host write while idle.
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_addr  = 8'h0A;
      cmd_data  = {NC{8'h03}};
      hit = 1'b0;
      for (k = 0; k < 200 && !hit; k++) begin
         @(negedge clk);
         hit = cmd_ready;
      end
      check_eq("t3_accept", hit, 1'b1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("t3_tx_start", tx_start, 1'b1);
      check_eq("t3_tx_addr", tx_addr, 8'h0A);
      check_eq("t3_tx_data", tx_data, {NC{8'h03}});

      // Random traffic, saturated host (starvation limit), random again.
      run_phase(2500, 0);
      run_phase(3000, 1);
      run_phase(1500, 0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;

`ifdef MAX7219_LINK_WD_EN
      // Withhold tx_done on the next frame: abort at start+WD and re-init.
      hit = 1'b0;
      for (k = 0; k < 2000 && !hit; k++) begin
         @(negedge clk);
         hit = tx_done;
      end
      check_eq("wd_idle_found", hit, 1'b1);
      m_en = 1'b0;
      withhold_done = 1'b1;
      hit = 1'b0;
      for (k = 0; k < 2000 && !hit; k++) begin
         @(negedge clk);
         hit = tx_start;
      end
      check_eq("wd_start_found", hit, 1'b1);
      hit = 1'b0;
      for (k = 0; k < 300 && !hit; ) begin
         @(negedge clk);
         k++;
         hit = tx_timeout;
      end
      check_eq("wd_latency", k, WD);
      check_eq("wd_init_done_cleared", init_done, 1'b0);
      withhold_done = 1'b0;
      for (int j = 0; j < 200 && !tx_start; j++) @(negedge clk);
      check_eq("wd_reinit_start", tx_start, 1'b1);
      check_eq("wd_reinit_addr", tx_addr, 8'h0F);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
